// File: rtl/alu_share_arbiter.sv
// Round-robin share of one four-function ALU between two valid/ready requesters.
// Results land in a single-entry, ID-tagged output register with downstream backpressure.
module alu_share_arbiter #(
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req0_valid,
    input  logic [N-1:0]      req0_A,
    input  logic [N-1:0]      req0_B,
    input  logic [1:0]        req0_Func,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [N-1:0]      req1_A,
    input  logic [N-1:0]      req1_B,
    input  logic [1:0]        req1_Func,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [2*N-1:0]    res_data,
    output logic              res_id,
    input  logic              res_ready,
    output logic [CW-1:0]     op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [2*N-1:0]     res_data_q;
    logic               res_id_q;
    logic [CW-1:0]      op_count_q;
    logic               last_grant_q;

    logic               slot_free_s;
    logic               grant1_s;
    logic               accept_s;
    logic               handoff_s;
    logic [N-1:0]       op_a_s;
    logic [N-1:0]       op_b_s;
    logic [1:0]         op_func_s;
    logic [2*N-1:0]     alu_s;

    function automatic logic [2*N-1:0] alu_f(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic [1:0]   func);
        logic [N:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (func)
            2'b00:   alu_f = {{(N-1){1'b0}}, sum};
            2'b01:   alu_f = {{(2*N-1){1'b0}}, |{a, b}};
            2'b10:   alu_f = {{(2*N-1){1'b0}}, &{a, b}};
            2'b11:   alu_f = {a, b};
            default: alu_f = {(2*N){1'b0}};
        endcase
    endfunction

    // Grant selection, handshake readies and operand mux for the ALU.
    always_comb begin
        slot_free_s = (state_q == EMPTY) || res_ready;
        // On contention the requester not granted last time wins.
        if (req0_valid && req1_valid) begin
            grant1_s = ~last_grant_q;
        end else begin
            grant1_s = req1_valid;
        end
        accept_s   = Resetn && slot_free_s && (req0_valid || req1_valid);
        handoff_s  = (state_q == FULL) && res_ready;
        req0_ready = accept_s && !grant1_s;
        req1_ready = accept_s && grant1_s;
        if (grant1_s) begin
            op_a_s    = req1_A;
            op_b_s    = req1_B;
            op_func_s = req1_Func;
        end else begin
            op_a_s    = req0_A;
            op_b_s    = req0_B;
            op_func_s = req0_Func;
        end
        alu_s = alu_f(op_a_s, op_b_s, op_func_s);
    end

    // Output register FSM, grant pointer and handoff counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= EMPTY;
            res_data_q   <= {(2*N){1'b0}};
            res_id_q     <= 1'b0;
            op_count_q   <= {CW{1'b0}};
            last_grant_q <= 1'b1;
        end else begin
            if (handoff_s) begin
                op_count_q <= op_count_q + {{(CW-1){1'b0}}, 1'b1};
            end
            if (accept_s) begin
                res_data_q   <= alu_s;
                res_id_q     <= grant1_s;
                last_grant_q <= grant1_s;
            end
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (handoff_s && !accept_s) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed vectors push expected results,
// an independent monitor pops and compares on every result handoff.
module tb_alu_share_arbiter;
    localparam int N  = 4;
    localparam int CW = 4;

    logic           Clock;
    logic           Resetn;
    logic           req0_valid, req1_valid;
    logic [N-1:0]   req0_A, req0_B, req1_A, req1_B;
    logic [1:0]     req0_Func, req1_Func;
    logic           req0_ready, req1_ready;
    logic           res_valid;
    logic [2*N-1:0] res_data;
    logic           res_id;
    logic           res_ready;
    logic [CW-1:0]  op_count;

    int checks   = 0;
    int failures = 0;
    logic [2*N:0] sb[$];

    alu_share_arbiter #(.N(N), .CW(CW)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .req0_valid(req0_valid), .req0_A(req0_A), .req0_B(req0_B),
        .req0_Func(req0_Func), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_A(req1_A), .req1_B(req1_B),
        .req1_Func(req1_Func), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .op_count(op_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check readies mid-cycle, queue the expected result.
    task automatic step(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] f0,
                        input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] f1,
                        input logic rr, input logic e0, input logic e1, input logic [7:0] ed);
        req0_valid = v0; req0_A = a0; req0_B = b0; req0_Func = f0;
        req1_valid = v1; req1_A = a1; req1_B = b1; req1_Func = f1;
        res_ready  = rr;
        @(negedge Clock);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        if (e0 || e1) sb.push_back({e1, ed});
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 2'b00, rr, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compares every handoff against the scoreboard and tracks the count.
    initial begin
        logic [3:0]   exp_cnt;
        logic [2*N:0] e;
        exp_cnt = 4'd0;
        forever begin
            @(negedge Clock);
            if (!Resetn) begin
                exp_cnt = 4'd0;
            end else begin
                chk("op_count_track", {28'd0, op_count}, {28'd0, exp_cnt});
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got id=%0d data=%0h expected none", res_id, res_data);
                    end else begin
                        e = sb.pop_front();
                        chk("res_data", {24'd0, res_data}, {24'd0, e[7:0]});
                        chk("res_id", {31'd0, res_id}, {31'd0, e[8]});
                    end
                    exp_cnt = exp_cnt + 4'd1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        Resetn = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b1; req0_A = 4'h0; req0_B = 4'h0; req0_Func = 2'b00;
        req1_valid = 1'b0; req1_A = 4'h0; req1_B = 4'h0; req1_Func = 2'b00;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {24'd0, res_data}, 32'd0);
        chk("rst_res_id", {31'd0, res_id}, 32'd0);
        chk("rst_op_count", {28'd0, op_count}, 32'd0);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        Resetn = 1'b1;

        // Single req0 add with carry.
        step(1'b1, 4'h9, 4'h8, 2'b00, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 8'h11);
        idle(1'b1);
        chk("op_count_after_first", {28'd0, op_count}, 32'd1);

        // req1 back-to-back through the other functions.
        step(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 4'h2, 2'b01, 1'b1, 1'b0, 1'b1, 8'h01);
        step(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'hF, 4'hF, 2'b10, 1'b1, 1'b0, 1'b1, 8'h01);
        step(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'hF, 4'hE, 2'b10, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h3, 4'h5, 2'b11, 1'b1, 1'b0, 1'b1, 8'h35);
        idle(1'b1);

        // Contention: strict alternation starting with req0.
        step(1'b1, 4'h1, 4'h2, 2'b00, 1'b1, 4'hF, 4'h1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h03);
        step(1'b1, 4'h7, 4'h7, 2'b11, 1'b1, 4'hF, 4'h1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h10);
        step(1'b1, 4'h7, 4'h7, 2'b11, 1'b1, 4'h0, 4'h0, 2'b01, 1'b1, 1'b1, 1'b0, 8'h77);
        step(1'b1, 4'hA, 4'h5, 2'b00, 1'b1, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 4'hA, 4'h5, 2'b00, 1'b1, 4'hC, 4'h3, 2'b10, 1'b1, 1'b1, 1'b0, 8'h0F);
        step(1'b1, 4'h1, 4'h1, 2'b00, 1'b1, 4'hC, 4'h3, 2'b10, 1'b1, 1'b0, 1'b1, 8'h00);
        idle(1'b1);
        chk("op_count_after_rr", {28'd0, op_count}, 32'd12);

        // Backpressure: result held, no acceptance, then handoff plus accept together.
        step(1'b1, 4'h3, 4'h4, 2'b00, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 8'h07);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h1, 4'h1, 2'b00, 1'b1, 4'h5, 4'h6, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_res_data", {24'd0, res_data}, 32'h07);
            chk("bp_res_id", {31'd0, res_id}, 32'd0);
        end
        step(1'b1, 4'h1, 4'h1, 2'b00, 1'b1, 4'h5, 4'h6, 2'b00, 1'b1, 1'b0, 1'b1, 8'h0B);
        idle(1'b1);
        chk("op_count_after_bp", {28'd0, op_count}, 32'd14);

        // Asynchronous reset while a result is pending.
        step(1'b1, 4'h2, 4'h3, 2'b11, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 8'h23);
        chk("pre_rst_res_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        Resetn = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("async_rst_res_data", {24'd0, res_data}, 32'd0);
        chk("async_rst_res_id", {31'd0, res_id}, 32'd0);
        chk("async_rst_op_count", {28'd0, op_count}, 32'd0);
        chk("async_rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("async_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        step(1'b1, 4'h6, 4'h6, 2'b00, 1'b1, 4'h2, 4'h2, 2'b00, 1'b1, 1'b1, 1'b0, 8'h0C);
        step(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h2, 4'h2, 2'b00, 1'b1, 1'b0, 1'b1, 8'h04);
        idle(1'b1);

        // Counter wrap with a 4-bit counter.
        Resetn = 1'b0;
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int k = 0; k < 19; k++) begin
            logic [3:0] kb;
            logic       act;
            kb  = k[3:0];
            act = (k < 17);
            step(act, kb, ~kb, 2'b11, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, act, 1'b0, {kb, ~kb});
            if (k == 15) chk("wrap_after_15", {28'd0, op_count}, 32'd15);
            if (k == 16) chk("wrap_after_16", {28'd0, op_count}, 32'd0);
            if (k == 17) chk("wrap_after_17", {28'd0, op_count}, 32'd1);
        end
        idle(1'b1);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
